// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: |A - B| plus a sign flag, one digit per clock, LSD first.
// Define BCD_SUB_CHECK_EN to reject operands holding a digit above 9 (sets invalid).
module bcd_sub_serial #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg,
   output logic                  invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // {carry, digit} of x + (9 - y) + cin with decimal correction
   function automatic logic [4:0] dec_step(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
      logic [4:0] t;
      logic [4:0] u;
      t = {1'b0, x} + (5'd9 - {1'b0, y}) + {4'b0000, cin};
      u = t - 5'd10;
      if (t > 5'd9) begin
         dec_step = {1'b1, u[3:0]};
      end else begin
         dec_step = {1'b0, t[3:0]};
      end
   endfunction

`ifdef BCD_SUB_CHECK_EN
   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction
`endif

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    res_q, res_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            c_q, c_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W-1:0]    diff_q, diff_d;
   logic            neg_q, neg_d;
`ifdef BCD_SUB_CHECK_EN
   logic            invalid_q, invalid_d;
`endif
   logic [4:0]      step_s;
   logic [3:0]      a_dig_s, b_dig_s, r_dig_s;

   assign a_dig_s = a_q[{idx_q, 2'b00} +: 4];
   assign b_dig_s = b_q[{idx_q, 2'b00} +: 4];
   assign r_dig_s = res_q[{idx_q, 2'b00} +: 4];

   // Next-state and datapath for the digit-serial subtract / recomplement sequence
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      idx_d   = idx_q;
      c_d     = c_q;
      diff_d  = diff_q;
      neg_d   = neg_q;
`ifdef BCD_SUB_CHECK_EN
      invalid_d = invalid_q;
`endif
      step_s  = 5'd0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               c_d     = 1'b1;
               res_d   = '0;
               state_d = SUB;
`ifdef BCD_SUB_CHECK_EN
               if (has_bad_digit(a) || has_bad_digit(b)) begin
                  invalid_d = 1'b1;
                  diff_d    = '0;
                  neg_d     = 1'b0;
                  state_d   = DONE;
               end else begin
                  invalid_d = 1'b0;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SUB: begin
            step_s                     = dec_step(a_dig_s, b_dig_s, c_q);
            res_d[{idx_q, 2'b00} +: 4] = step_s[3:0];
            c_d                        = step_s[4];
            idx_d                      = idx_q + IW'(1);
            if (idx_q == LAST) begin
               // A final carry of 1 means no borrow out, so A >= B
               if (step_s[4]) begin
                  neg_d   = 1'b0;
                  diff_d  = res_d;
                  state_d = DONE;
               end else begin
                  neg_d   = 1'b1;
                  idx_d   = '0;
                  c_d     = 1'b1;
                  state_d = FIX;
               end
            end else begin
               state_d = SUB;
            end
         end
         FIX: begin
            step_s                     = dec_step(4'd0, r_dig_s, c_q);
            res_d[{idx_q, 2'b00} +: 4] = step_s[3:0];
            c_d                        = step_s[4];
            idx_d                      = idx_q + IW'(1);
            if (idx_q == LAST) begin
               diff_d  = res_d;
               state_d = DONE;
            end else begin
               state_d = FIX;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_q == DONE);
   end

   // State and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         neg_q   <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
         invalid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         neg_q   <= neg_d;
`ifdef BCD_SUB_CHECK_EN
         invalid_q <= invalid_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign neg  = neg_q;
`ifdef BCD_SUB_CHECK_EN
   assign invalid = invalid_q;
`else
   assign invalid = 1'b0;
`endif

endmodule
